// File: rtl/dm_bus_ctrl.sv
// MEM-stage data memory and device-bus controller: one load/store per request, served from
// a word RAM or forwarded to a memory-mapped device with ack handshake and timeout.
module dm_bus_ctrl #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned DEV_NUM     = 2,
  parameter logic [31:0] DEV_BASE    = 32'h7F00,
  parameter logic [31:0] DEV_STRIDE  = 32'h10,
  parameter int unsigned DEV_WORDS   = 3,
  parameter int unsigned DEV_RO_WORD = 2,
  parameter int unsigned TIMEOUT     = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [1:0]         req_size,
  input  logic               req_signed,
  input  logic [31:0]        req_addr,
  input  logic [31:0]        req_wdata,
  input  logic [31:0]        req_pc,
  output logic               resp_valid,
  output logic [31:0]        resp_rdata,
  output logic [1:0]         resp_exc,
  output logic [DEV_NUM-1:0] dev_sel,
  output logic               dev_we,
  output logic [31:0]        dev_addr,
  output logic [31:0]        dev_wdata,
  input  logic [31:0]        dev_rdata,
  input  logic               dev_ack
);

  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam int unsigned CW        = $clog2(TIMEOUT + 1);
  localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH_WORDS);
  localparam logic [31:0] WIN_BYTES = 32'(4 * DEV_WORDS);

  typedef enum logic [1:0] {StIdle, StDevWait, StResp} state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [31:0]          word_q, word_d;
  logic [1:0]           size_q, size_d;
  logic                 signed_q, signed_d;
  logic [1:0]           lane_q, lane_d;
  logic [1:0]           exc_q, exc_d;
  logic [DEV_NUM-1:0]   sel_q, sel_d;
  logic                 dev_we_q, dev_we_d;
  logic [31:0]          daddr_q, daddr_d;
  logic [31:0]          dwdata_q, dwdata_d;
  logic [31:0]          mem_q [DEPTH_WORDS];

  logic                 misaligned, ram_hit, dev_hit, req_exc, ram_we, timeout_hit;
  logic [DEV_NUM-1:0]   dev_onehot;
  logic [31:0]          dev_offs, dev_word;
  logic [AW-1:0]        ram_idx;
  logic [31:0]          ram_rd, ram_merged, wd_lanes, lane_word, load_ext;
  logic [3:0]           be;
  logic [CW-1:0]        cnt_inc;

  // Request decode: address windows and exception conditions
  always_comb begin
    dev_hit    = 1'b0;
    dev_onehot = '0;
    dev_offs   = '0;
    dev_word   = '0;
    for (int unsigned k = 0; k < DEV_NUM; k++) begin
      // Wraps to a large value below the window base, so one compare covers both bounds
      dev_offs = req_addr - (DEV_BASE + DEV_STRIDE * 32'(k));
      if (dev_offs < WIN_BYTES) begin
        dev_hit       = 1'b1;
        dev_onehot    = '0;
        dev_onehot[k] = 1'b1;
        dev_word      = dev_offs >> 2;
      end
    end
  end

  assign ram_hit    = req_addr < RAM_BYTES;
  assign misaligned = (req_size[1] && (req_addr[1:0] != 2'b00)) ||
                      ((req_size == 2'b01) && req_addr[0]);
  assign req_exc    = misaligned || (!ram_hit && !dev_hit) ||
                      (!ram_hit && dev_hit && !req_size[1]) ||
                      (!ram_hit && dev_hit && req_we && (dev_word == 32'(DEV_RO_WORD)));

  assign ram_idx = req_addr[AW+1:2];
  assign ram_rd  = mem_q[ram_idx];
  assign ram_we  = req_valid && (state_q == StIdle) && !req_exc && ram_hit && req_we;

  always_comb begin
    be       = 4'b0000;
    wd_lanes = '0;
    unique case (req_size)
      2'b00: begin
        be       = 4'b0001 << req_addr[1:0];
        wd_lanes = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be       = req_addr[1] ? 4'b1100 : 4'b0011;
        wd_lanes = {2{req_wdata[15:0]}};
      end
      default: begin
        be       = 4'b1111;
        wd_lanes = req_wdata;
      end
    endcase
    ram_merged = ram_rd;
    for (int unsigned l = 0; l < 4; l++) begin
      if (be[l]) ram_merged[8*l +: 8] = wd_lanes[8*l +: 8];
    end
  end

  assign cnt_inc     = cnt_q + 1'b1;
  assign timeout_hit = cnt_inc == CW'(TIMEOUT);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    word_d   = word_q;
    size_d   = size_q;
    signed_d = signed_q;
    lane_d   = lane_q;
    exc_d    = exc_q;
    sel_d    = sel_q;
    dev_we_d = dev_we_q;
    daddr_d  = daddr_q;
    dwdata_d = dwdata_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          size_d   = req_size;
          signed_d = req_signed;
          lane_d   = req_addr[1:0];
          word_d   = '0;
          exc_d    = 2'b00;
          cnt_d    = '0;
          if (req_exc) begin
            exc_d   = req_we ? 2'b10 : 2'b01;
            state_d = StResp;
          end else if (ram_hit) begin
            if (!req_we) word_d = ram_rd;
            state_d = StResp;
          end else begin
            sel_d    = dev_onehot;
            dev_we_d = req_we;
            daddr_d  = {req_addr[31:2], 2'b00};
            dwdata_d = req_wdata;
            state_d  = StDevWait;
          end
        end
      end
      StDevWait: begin
        cnt_d = cnt_inc;
        if (dev_ack) begin
          if (!dev_we_q) word_d = dev_rdata;
          sel_d    = '0;
          dev_we_d = 1'b0;
          state_d  = StResp;
        end else if (timeout_hit) begin
          exc_d    = 2'b11;
          sel_d    = '0;
          dev_we_d = 1'b0;
          state_d  = StResp;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      word_q   <= '0;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      lane_q   <= 2'b00;
      exc_q    <= 2'b00;
      sel_q    <= '0;
      dev_we_q <= 1'b0;
      daddr_q  <= '0;
      dwdata_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      word_q   <= word_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      lane_q   <= lane_d;
      exc_q    <= exc_d;
      sel_q    <= sel_d;
      dev_we_q <= dev_we_d;
      daddr_q  <= daddr_d;
      dwdata_q <= dwdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= '0;
    end else if (ram_we) begin
      mem_q[ram_idx] <= ram_merged;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset && ram_we) begin
      $display("%d@%h: *%h <= %h", $time, req_pc, {req_addr[31:2], 2'b00}, ram_merged);
    end
  end
`endif

  // Lane extraction happens in RESP from the latched word
  always_comb begin
    lane_word = '0;
    load_ext  = word_q;
    unique case (size_q)
      2'b00: begin
        lane_word = word_q >> {lane_q, 3'b000};
        load_ext  = {{24{signed_q & lane_word[7]}}, lane_word[7:0]};
      end
      2'b01: begin
        lane_word = word_q >> {lane_q[1], 4'b0000};
        load_ext  = {{16{signed_q & lane_word[15]}}, lane_word[15:0]};
      end
      default: load_ext = word_q;
    endcase
  end

  assign req_ready  = state_q == StIdle;
  assign resp_valid = state_q == StResp;
  assign resp_rdata = resp_valid ? load_ext : '0;
  assign resp_exc   = resp_valid ? exc_q : 2'b00;
  assign dev_sel    = sel_q;
  assign dev_we     = dev_we_q;
  assign dev_addr   = daddr_q;
  assign dev_wdata  = dwdata_q;

endmodule

// File: tb/tb_dm_bus_ctrl.sv
// Directed bench for dm_bus_ctrl: RAM loads/stores, exceptions, device handshake and timeout.
module tb_dm_bus_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b10;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [31:0] req_pc = 32'h0000_1000;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_exc;
  logic [1:0]  dev_sel;
  logic        dev_we;
  logic [31:0] dev_addr;
  logic [31:0] dev_wdata;
  logic [31:0] dev_rdata = '0;
  logic        dev_ack = 1'b0;

  int checks = 0;
  int errors = 0;

  dm_bus_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_pc     (req_pc),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_exc   (resp_exc),
    .dev_sel    (dev_sel),
    .dev_we     (dev_we),
    .dev_addr   (dev_addr),
    .dev_wdata  (dev_wdata),
    .dev_rdata  (dev_rdata),
    .dev_ack    (dev_ack)
  );

  always #5 clk = ~clk;

  // Present one request in IDLE; returns 1ns after the accepting edge
  task automatic do_req(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_pc    = req_pc + 32'd4;
  endtask

  // Request then sample the response on the following negedge
  task automatic ram_op(input string name, input logic we, input logic [1:0] sz,
                        input logic sg, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rdata, input logic [1:0] exp_exc);
    do_req(we, sz, sg, a, wd);
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b1 || resp_rdata !== exp_rdata || resp_exc !== exp_exc ||
        dev_sel !== 2'b00) begin
      errors++;
      $display("FAIL %s: valid=%b rdata=%h exc=%b sel=%b, want valid=1 rdata=%h exc=%b sel=00",
               name, resp_valid, resp_rdata, resp_exc, dev_sel, exp_rdata, exp_exc);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({req_ready, resp_valid, resp_exc, dev_sel, dev_we} !== 7'b1_0_00_00_0) begin
      errors++;
      $display("FAIL reset_ctrl: ready=%b valid=%b exc=%b sel=%b we=%b, want 1 0 00 00 0",
               req_ready, resp_valid, resp_exc, dev_sel, dev_we);
    end
    checks++;
    if (resp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_rdata: got %h want 00000000", resp_rdata);
    end
  endtask

  task automatic test_ram_word;
    ram_op("sw_0x10", 1'b1, 2'b10, 1'b0, 32'h10, 32'h1234_5678, 32'h0, 2'b00);
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL resp_pulse: valid=%b ready=%b want valid=0 ready=1", resp_valid, req_ready);
    end
    ram_op("lb_0x13", 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 32'h0000_0012, 2'b00);
    ram_op("lbu_0x13", 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 32'h0000_0012, 2'b00);
    ram_op("lh_0x12", 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 32'h0000_1234, 2'b00);
    ram_op("lw_0x10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h1234_5678, 2'b00);
  endtask

  task automatic test_ram_byte;
    ram_op("sb_0x01", 1'b1, 2'b00, 1'b0, 32'h01, 32'hFFFF_FF80, 32'h0, 2'b00);
    ram_op("lb_0x01", 1'b0, 2'b00, 1'b1, 32'h01, 32'h0, 32'hFFFF_FF80, 2'b00);
    ram_op("lbu_0x01", 1'b0, 2'b00, 1'b0, 32'h01, 32'h0, 32'h0000_0080, 2'b00);
    ram_op("lh_0x00", 1'b0, 2'b01, 1'b1, 32'h00, 32'h0, 32'hFFFF_8000, 2'b00);
    ram_op("lw_0x00", 1'b0, 2'b10, 1'b0, 32'h00, 32'h0, 32'h0000_8000, 2'b00);
  endtask

  task automatic test_exceptions;
    ram_op("lw_mis_0x2", 1'b0, 2'b10, 1'b0, 32'h2, 32'h0, 32'h0, 2'b01);
    ram_op("sh_0x7f01", 1'b1, 2'b01, 1'b0, 32'h7F01, 32'h5555, 32'h0, 2'b10);
    ram_op("sw_ro_0x7f08", 1'b1, 2'b10, 1'b0, 32'h7F08, 32'h1, 32'h0, 2'b10);
    ram_op("lw_oor_0x7f0c", 1'b0, 2'b10, 1'b0, 32'h7F0C, 32'h0, 32'h0, 2'b01);
    ram_op("lh_dev_0x7f00", 1'b0, 2'b01, 1'b0, 32'h7F00, 32'h0, 32'h0, 2'b01);
    ram_op("sw_mis_0x3", 1'b1, 2'b10, 1'b0, 32'h3, 32'hDEAD_BEEF, 32'h0, 2'b10);
    ram_op("lw_0x00_intact", 1'b0, 2'b10, 1'b0, 32'h00, 32'h0, 32'h0000_8000, 2'b00);
  endtask

  task automatic test_dev_ack;
    int held;
    held = 0;
    do_req(1'b0, 2'b10, 1'b0, 32'h7F14, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (dev_sel === 2'b10 && dev_addr === 32'h7F14 && dev_we === 1'b0 && !resp_valid) held++;
      if (i == 2) begin
        dev_ack   = 1'b1;
        dev_rdata = 32'h0000_CAFE;
      end
    end
    @(posedge clk);
    #1 dev_ack = 1'b0;
    checks++;
    if (held !== 3) begin
      errors++;
      $display("FAIL dev_sel_held: got %0d cycles want 3", held);
    end
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b1 || resp_rdata !== 32'h0000_CAFE || resp_exc !== 2'b00 ||
        dev_sel !== 2'b00) begin
      errors++;
      $display("FAIL dev_load_resp: valid=%b rdata=%h exc=%b sel=%b want 1 0000cafe 00 00",
               resp_valid, resp_rdata, resp_exc, dev_sel);
    end
  endtask

  task automatic test_dev_timeout;
    int n;
    n = 0;
    do_req(1'b1, 2'b10, 1'b0, 32'h7F00, 32'h0000_A5A5);
    @(negedge clk);
    checks++;
    if (dev_sel !== 2'b01 || dev_we !== 1'b1 || dev_wdata !== 32'h0000_A5A5 ||
        dev_addr !== 32'h7F00) begin
      errors++;
      $display("FAIL dev_store_drive: sel=%b we=%b wdata=%h addr=%h want 01 1 0000a5a5 00007f00",
               dev_sel, dev_we, dev_wdata, dev_addr);
    end
    n = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (resp_valid) break;
      if (dev_sel !== 2'b00) n++;
    end
    checks++;
    if (n !== 15 || resp_valid !== 1'b1 || resp_exc !== 2'b11 || resp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL dev_timeout: wait=%0d valid=%b exc=%b rdata=%h want 15 1 11 00000000",
               n, resp_valid, resp_exc, resp_rdata);
    end
    // Ack arrives on the very cycle the counter would expire
    do_req(1'b1, 2'b10, 1'b0, 32'h7F04, 32'h1);
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      if (i == 15) dev_ack = 1'b1;
    end
    @(posedge clk);
    #1 dev_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b1 || resp_exc !== 2'b00) begin
      errors++;
      $display("FAIL ack_on_timeout: valid=%b exc=%b want 1 00", resp_valid, resp_exc);
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_size  = 2'b10;
    req_addr  = 32'h10;
    @(posedge clk);
    #1;
    req_size   = 2'b00;
    req_signed = 1'b0;
    req_addr   = 32'h11;
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b1 || resp_rdata !== 32'h1234_5678 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first: valid=%b rdata=%h ready=%b want 1 12345678 0",
               resp_valid, resp_rdata, req_ready);
    end
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_gap: valid=%b ready=%b want 0 1", resp_valid, req_ready);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b1 || resp_rdata !== 32'h0000_0056) begin
      errors++;
      $display("FAIL b2b_second: valid=%b rdata=%h want 1 00000056", resp_valid, resp_rdata);
    end
  endtask

  task automatic test_reset_mid;
    int seen;
    seen = 0;
    do_req(1'b0, 2'b10, 1'b0, 32'h7F10, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || dev_sel !== 2'b00 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: ready=%b sel=%b valid=%b want 1 00 0",
               req_ready, dev_sel, resp_valid);
    end
    repeat (4) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL reset_no_resp: got %0d responses want 0", seen);
    end
    ram_op("lw_after_reset", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h0, 2'b00);
  endtask

  initial begin
    test_reset();
    test_ram_word();
    test_ram_byte();
    test_exceptions();
    test_dev_ack();
    test_dev_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
